// File: rtl/bcd_day_entry_pkg.sv
// -----------------------------------------------------------------------------
// bcd_day_entry_pkg
// Shared definitions for the BCD day-of-month entry block: FSM state
// encoding, result width and BCD digit limits.
// -----------------------------------------------------------------------------
package bcd_day_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,   // waiting for the tens digit
        ST_WAIT_UNITS = 2'd1,   // tens captured, waiting for the units digit
        ST_CHECK      = 2'd2    // both digits captured, range check this cycle
    } state_t;

    localparam int DAY_W          = 5;  // binary day value width
    localparam int BIN_W          = 6;  // raw two-digit conversion width
    localparam int BCD_MAX_DIGIT  = 9;  // largest legal BCD digit
    localparam int TENS_MAX_DIGIT = 3;  // largest tens digit a day can have

endpackage

// File: rtl/bcd_day_entry_bcd2_to_bin.sv
// -----------------------------------------------------------------------------
// bcd2_to_bin
// Combinational two-digit BCD to binary converter: bin_o = tens*10 + units,
// built from shifts and adds. The result is BIN_W bits wide, which covers
// every tens digit up to 5 (so it is also usable for hour/month entry).
//
// Ports:
//   tens_i  [3:0]       tens BCD digit
//   units_i [3:0]       units BCD digit
//   bin_o   [BIN_W-1:0] binary value
// -----------------------------------------------------------------------------
module bcd2_to_bin
    import bcd_day_entry_pkg::*;
(
    input  logic [3:0]       tens_i,
    input  logic [3:0]       units_i,
    output logic [BIN_W-1:0] bin_o
);

    logic [BIN_W-1:0] tens_ext;
    logic [BIN_W-1:0] units_ext;

    assign tens_ext  = {2'b00, tens_i};
    assign units_ext = {2'b00, units_i};

    // tens*10 = tens*8 + tens*2
    assign bin_o = (tens_ext << 3) + (tens_ext << 1) + units_ext;

endmodule

// File: rtl/bcd_day_entry.sv
// -----------------------------------------------------------------------------
// bcd_day_entry
// Sequential BCD day-of-month entry. Takes a tens digit then a units digit
// on digit_stb, converts them to binary and range-checks the day. A good
// day updates DD with a one-cycle dd_valid pulse; a bad digit or an
// out-of-range day gives a one-cycle err pulse and leaves DD alone.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset (highest priority)
//   digit_in   BCD digit, sampled when digit_stb=1
//   digit_stb  one-cycle digit strobe
//   clear      synchronous abort of the current entry
//   DD         last accepted binary day
//   dd_valid   one-cycle pulse when DD is updated
//   err        one-cycle pulse when an entry is rejected
//   busy       high while in WAIT_UNITS or CHECK
//   tens_q     captured tens digit (display echo)
//   units_q    captured units digit (display echo)
// -----------------------------------------------------------------------------
module bcd_day_entry
    import bcd_day_entry_pkg::*;
#(
    parameter int MIN_DAY = 1,
    parameter int MAX_DAY = 31   // must be <= 31 to fit DAY_W bits
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       digit_in,
    input  logic             digit_stb,
    input  logic             clear,
    output logic [DAY_W-1:0] DD,
    output logic             dd_valid,
    output logic             err,
    output logic             busy,
    output logic [3:0]       tens_q,
    output logic [3:0]       units_q
);

    localparam logic [BIN_W-1:0] MIN_V     = BIN_W'(MIN_DAY);
    localparam logic [BIN_W-1:0] MAX_V     = BIN_W'(MAX_DAY);
    localparam logic [3:0]       TENS_MAX  = 4'(TENS_MAX_DIGIT);
    localparam logic [3:0]       UNITS_MAX = 4'(BCD_MAX_DIGIT);

    state_t           state_q;
    logic [DAY_W-1:0] dd_q;
    logic             dd_valid_q;
    logic             err_q;
    logic             busy_q;
    logic [3:0]       tens_digit_q;
    logic [3:0]       units_digit_q;
    logic [BIN_W-1:0] value_d;
    logic             in_range_d;

    bcd2_to_bin u_bcd2_to_bin (
        .tens_i  (tens_digit_q),
        .units_i (units_digit_q),
        .bin_o   (value_d)
    );

    assign in_range_d = (value_d >= MIN_V) && (value_d <= MAX_V);

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of statement order.
        // The pulse outputs default low each cycle and are only raised below.
        dd_valid_q <= 1'b0;
        err_q      <= 1'b0;

        if (reset) begin
            state_q       <= ST_IDLE;
            dd_q          <= '0;
            tens_digit_q  <= '0;
            units_digit_q <= '0;
            busy_q        <= 1'b0;
        end else if (clear) begin
            // Abort: a coincident digit strobe is dropped, DD is kept.
            state_q       <= ST_IDLE;
            tens_digit_q  <= '0;
            units_digit_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (digit_stb) begin
                        if (digit_in > TENS_MAX) begin
                            err_q <= 1'b1;
                        end else begin
                            tens_digit_q  <= digit_in;
                            units_digit_q <= '0;
                            state_q       <= ST_WAIT_UNITS;
                            busy_q        <= 1'b1;
                        end
                    end
                end

                ST_WAIT_UNITS: begin
                    if (digit_stb) begin
                        if (digit_in > UNITS_MAX) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            units_digit_q <= digit_in;
                            state_q       <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    // Any strobe arriving here is deliberately ignored.
                    if (in_range_d) begin
                        dd_q       <= value_d[DAY_W-1:0];
                        dd_valid_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DD       = dd_q;
    assign dd_valid = dd_valid_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign tens_q   = tens_digit_q;
    assign units_q  = units_digit_q;

endmodule
